// File: rtl/multdiv_pkg.sv
// Shared encodings and defaults for the multiply/divide sequencer.
package multdiv_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_WAIT  = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    localparam logic OP_MULT = 1'b0;
    localparam logic OP_DIV  = 1'b1;

    localparam int TIMEOUT_DEFAULT = 40;
    // The timeout counter is 6 bits wide, so TIMEOUT must not exceed 64.
    localparam int CNT_BITS        = 6;

endpackage

// File: rtl/multdiv_timeout_counter.sv
// Counts WAIT cycles and flags when the unit has had its full time budget.
module multdiv_timeout_counter
    import multdiv_pkg::*;
#(
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [CNT_BITS-1:0] count_q, count_d;

    // Clear has priority over counting so START always restarts from zero.
    always_comb begin
        count_d = clr ? '0 : count_q + CNT_BITS'(1);
    end

    register_Nbit #(.N(CNT_BITS)) u_count (
        .clock (clock),
        .reset (reset),
        .en    (clr | en),
        .d     (count_d),
        .q     (count_q)
    );

    assign expired = (count_q == CNT_BITS'(TIMEOUT - 1));

endmodule

// File: rtl/register_Nbit.sv
// Generic N-bit register with synchronous active-high reset and load enable.
module register_Nbit #(
    parameter int N = 6
) (
    input  logic         clock,
    input  logic         reset,
    input  logic         en,
    input  logic [N-1:0] d,
    output logic [N-1:0] q
);

    logic [N-1:0] data_q, data_d;

    // Hold the current value unless a load is requested.
    always_comb begin
        data_d = en ? d : data_q;
    end

    // State register; reset is sampled on the clock edge.
    always_ff @(posedge clock) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;

endmodule

// File: rtl/multdiv_ctrl.sv
// Sequences one MULT/DIV request through the shared units: latch operands,
// pulse start, wait for ready (with timeout), and write back with its tag.
module multdiv_ctrl
    import multdiv_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int RD_BITS = 5,
    parameter int TIMEOUT = TIMEOUT_DEFAULT
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               req_valid,
    input  logic               req_op,
    input  logic [WIDTH-1:0]   req_a,
    input  logic [WIDTH-1:0]   req_b,
    input  logic [RD_BITS-1:0] req_rd,
    input  logic               flush,
    output logic [WIDTH-1:0]   unit_operandA,
    output logic [WIDTH-1:0]   unit_operandB,
    output logic               unit_ctrl_MULT,
    output logic               unit_ctrl_DIV,
    input  logic [WIDTH-1:0]   unit_result,
    input  logic               unit_exception,
    input  logic               unit_resultRDY,
    output logic               unit_sel,
    output logic               stall,
    output logic               busy,
    output logic               wb_valid,
    output logic [WIDTH-1:0]   wb_data,
    output logic [RD_BITS-1:0] wb_rd,
    output logic               wb_exception
);

    state_e             state_q, state_d;
    logic               op_q, op_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [RD_BITS-1:0] rd_q, rd_d;
    logic [WIDTH-1:0]   data_q, data_d;
    logic               exc_q, exc_d;
    logic               cnt_clr, cnt_en, expired;

    multdiv_timeout_counter #(.TIMEOUT(TIMEOUT)) u_timeout (
        .clock   (clock),
        .reset   (reset),
        .clr     (cnt_clr),
        .en      (cnt_en),
        .expired (expired)
    );

    // Next-state and datapath-latch logic.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned, which would infer a latch.
        state_d = state_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        rd_d    = rd_q;
        data_d  = data_q;
        exc_d   = exc_q;
        cnt_clr = 1'b0;
        cnt_en  = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE: begin
                state_d = ST_IDLE;
                if (req_valid && !flush) begin
                    op_d = req_op;
                    a_d  = req_a;
                    b_d  = req_b;
                    rd_d = req_rd;
                    // Divide-by-zero is resolved here; the divider is never started.
                    if (req_op == OP_DIV && req_b == '0) begin
                        state_d = ST_DONE;
                        data_d  = '0;
                        exc_d   = 1'b1;
                    end else begin
                        state_d = ST_START;
                    end
                end
            end
            ST_START: begin
                // Ready is ignored here: the unit counters free-run and may be stale.
                cnt_clr = 1'b1;
                state_d = flush ? ST_IDLE : ST_WAIT;
            end
            ST_WAIT: begin
                cnt_en = 1'b1;
                if (flush) begin
                    state_d = ST_IDLE;
                end else if (unit_resultRDY) begin
                    state_d = ST_DONE;
                    data_d  = unit_result;
                    exc_d   = unit_exception;
                end else if (expired) begin
                    state_d = ST_DONE;
                    data_d  = '0;
                    exc_d   = 1'b1;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and latch registers with synchronous reset.
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
        if (reset) begin
            state_q <= ST_IDLE;
            op_q    <= OP_MULT;
            a_q     <= '0;
            b_q     <= '0;
            rd_q    <= '0;
            data_q  <= '0;
            exc_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            rd_q    <= rd_d;
            data_q  <= data_d;
            exc_q   <= exc_d;
        end
    end

    // Reset dominates the decoded outputs even during the reset cycle itself.
    assign unit_ctrl_MULT = !reset && (state_q == ST_START) && (op_q == OP_MULT);
    assign unit_ctrl_DIV  = !reset && (state_q == ST_START) && (op_q == OP_DIV);
    assign stall          = !reset && (((state_q == ST_IDLE) && req_valid) ||
                                       (state_q == ST_START) || (state_q == ST_WAIT));
    assign busy           = (state_q != ST_IDLE);
    assign wb_valid       = !reset && (state_q == ST_DONE) && !flush;
    assign unit_operandA  = a_q;
    assign unit_operandB  = b_q;
    assign unit_sel       = op_q;
    assign wb_data        = data_q;
    assign wb_rd          = rd_q;
    assign wb_exception   = exc_q;

endmodule

// File: tb/tb_multdiv_ctrl.sv
// Self-checking bench for multdiv_ctrl: behavioural unit model, writeback
// scoreboard, a vector table and hand-written multi-cycle sequences.
module tb_multdiv_ctrl;

    localparam logic OP_M = 1'b0;
    localparam logic OP_D = 1'b1;

    logic        clock = 1'b0;
    logic        reset, req_valid, req_op, flush;
    logic [31:0] req_a, req_b;
    logic [4:0]  req_rd;
    logic [31:0] unit_operandA, unit_operandB, unit_result, wb_data;
    logic        unit_ctrl_MULT, unit_ctrl_DIV, unit_exception, unit_resultRDY, unit_sel;
    logic        stall, busy, wb_valid, wb_exception;
    logic [4:0]  wb_rd;

    multdiv_ctrl dut (
        .clock(clock), .reset(reset), .req_valid(req_valid), .req_op(req_op),
        .req_a(req_a), .req_b(req_b), .req_rd(req_rd), .flush(flush),
        .unit_operandA(unit_operandA), .unit_operandB(unit_operandB),
        .unit_ctrl_MULT(unit_ctrl_MULT), .unit_ctrl_DIV(unit_ctrl_DIV),
        .unit_result(unit_result), .unit_exception(unit_exception),
        .unit_resultRDY(unit_resultRDY), .unit_sel(unit_sel), .stall(stall),
        .busy(busy), .wb_valid(wb_valid), .wb_data(wb_data), .wb_rd(wb_rd),
        .wb_exception(wb_exception)
    );

    always #5 clock = ~clock;

    // Unit model: ready one cycle, model_lat cycles after sampling a start pulse.
    int   model_lat = 16;
    int   model_cnt = 0;
    logic model_active = 1'b0;
    bit   never_rdy = 1'b0;
    bit   stale_rdy = 1'b0;

    always @(posedge clock) begin
        if (unit_ctrl_MULT || unit_ctrl_DIV) begin
            model_active <= 1'b1;
            model_cnt    <= 0;
        end else if (model_active) begin
            model_cnt <= model_cnt + 1;
            if (model_cnt == model_lat) model_active <= 1'b0;
        end
    end

    assign unit_resultRDY = (model_active && !never_rdy && model_cnt == model_lat) || stale_rdy;
    assign unit_exception = 1'b0;
    assign unit_result    = unit_sel ?
        ((unit_operandB == 32'd0) ? 32'd0 : $unsigned($signed(unit_operandA) / $signed(unit_operandB))) :
        unit_operandA * unit_operandB;

    int n_cmp = 0;
    int n_err = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Writeback scoreboard.
    typedef struct {
        logic [31:0] data;
        logic        exc;
        logic [4:0]  rd;
    } wb_t;
    wb_t sb[$];
    int  wb_seen = 0;

    // Pop and compare on every writeback; an unexpected one is a failure.
    always @(negedge clock) begin
        if (wb_valid === 1'b1) begin
            wb_seen++;
            if (sb.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL wb_unexpected: got data %h rd %0d, expected no writeback", wb_data, wb_rd);
            end else begin
                wb_t e;
                e = sb.pop_front();
                check("wb_data", wb_data, e.data);
                check("wb_exception", 32'(wb_exception), 32'(e.exc));
                check("wb_rd", 32'(wb_rd), 32'(e.rd));
            end
        end
    end

    // Start-pulse counters; both pulses at once is always illegal.
    int n_mult = 0;
    int n_div  = 0;
    always @(negedge clock) begin
        if (unit_ctrl_MULT === 1'b1) n_mult++;
        if (unit_ctrl_DIV === 1'b1)  n_div++;
        if (unit_ctrl_MULT === 1'b1 && unit_ctrl_DIV === 1'b1) begin
            n_cmp++;
            n_err++;
            $display("FAIL both_pulses: got MULT=1 DIV=1, expected at most one");
        end
    end

    typedef struct {
        logic        op;
        logic [31:0] a;
        logic [31:0] b;
        logic [4:0]  rd;
        logic [31:0] exp_data;
        logic        exp_exc;
        int          exp_lat;
        int          exp_mult;
        int          exp_div;
    } vec_t;
    vec_t vecs[6];

    task automatic drive_req(input logic op, input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd);
        req_valid = 1'b1;
        req_op    = op;
        req_a     = a;
        req_b     = b;
        req_rd    = rd;
    endtask

    // Wait (bounded) for wb_valid; returns cycles waited and cycles with stall low.
    task automatic wait_wb(output int lat, output int stall_lo);
        lat      = 0;
        stall_lo = 0;
        while (wb_valid !== 1'b1 && lat < 200) begin
            if (stall !== 1'b1) stall_lo++;
            @(negedge clock);
            lat++;
        end
        if (lat >= 200) begin
            n_cmp++;
            n_err++;
            $display("FAIL wb_wait: got no wb_valid in 200 cycles, expected one");
        end
    endtask

    task automatic run_one(input vec_t v);
        int lat, slo;
        n_mult = 0;
        n_div  = 0;
        sb.push_back('{v.exp_data, v.exp_exc, v.rd});
        drive_req(v.op, v.a, v.b, v.rd);
        @(negedge clock);
        req_valid = 1'b0;
        wait_wb(lat, slo);
        check("latency", lat, v.exp_lat);
        check("stall_busy", slo, 0);
        @(negedge clock);
        check("wb_one_cycle", 32'(wb_valid), 0);
        check("idle_after", 32'(busy), 0);
        check("mult_pulses", n_mult, v.exp_mult);
        check("div_pulses", n_div, v.exp_div);
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish by 1ms, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int lat, slo, seen0;

        vecs[0] = '{OP_M, 32'd7,     32'hFFFFFFFD, 5'd9,  32'hFFFFFFEB, 1'b0, 18, 1, 0};
        vecs[1] = '{OP_D, 32'd100,   32'd0,        5'd4,  32'd0,        1'b1, 0,  0, 0};
        vecs[2] = '{OP_D, 32'd100,   32'd7,        5'd3,  32'd14,       1'b0, 18, 0, 1};
        vecs[3] = '{OP_M, 32'h10000, 32'h10000,    5'd31, 32'd0,        1'b0, 18, 1, 0};
        vecs[4] = '{OP_D, 32'hFFFFFF9C, 32'd7,     5'd1,  32'hFFFFFFF2, 1'b0, 18, 0, 1};
        vecs[5] = '{OP_M, 32'd12345, 32'd678,      5'd2,  32'd8369910,  1'b0, 18, 1, 0};

        reset = 1'b1; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
        req_rd = '0; flush = 1'b0;
        repeat (3) @(negedge clock);
        check("rst_wb_valid", 32'(wb_valid), 0);
        check("rst_wb_data", wb_data, 0);
        check("rst_wb_rd", 32'(wb_rd), 0);
        check("rst_wb_exc", 32'(wb_exception), 0);
        check("rst_opA", unit_operandA, 0);
        check("rst_opB", unit_operandB, 0);
        check("rst_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 0);
        check("rst_sel", 32'(unit_sel), 0);
        check("rst_busy", 32'(busy), 0);
        check("rst_stall", 32'(stall), 0);
        reset = 1'b0;
        @(negedge clock);

        // Table-driven single requests.
        for (int i = 0; i < 6; i++) run_one(vecs[i]);

        // Flush on the 5th WAIT cycle; the late ready must not write back.
        seen0 = wb_seen;
        drive_req(OP_M, 32'd3, 32'd4, 5'd5);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (5) @(negedge clock);
        flush = 1'b1;
        @(negedge clock);
        flush = 1'b0;
        check("flush_idle", 32'(busy), 0);
        check("flush_stall", 32'(stall), 0);
        repeat (25) @(negedge clock);
        check("flush_no_wb", wb_seen, seen0);
        run_one('{OP_D, 32'd100, 32'd7, 5'd6, 32'd14, 1'b0, 18, 0, 1});

        // Back-to-back: second request held on req_valid, accepted in DONE.
        sb.push_back('{32'd42, 1'b0, 5'd10});
        sb.push_back('{32'd10, 1'b0, 5'd11});
        drive_req(OP_M, 32'd6, 32'd7, 5'd10);
        @(negedge clock);
        drive_req(OP_D, 32'd90, 32'd9, 5'd11);
        wait_wb(lat, slo);
        check("b2b_lat1", lat, 18);
        check("b2b_done_stall", 32'(stall), 0);
        @(negedge clock);
        req_valid = 1'b0;
        check("b2b_start_div", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 1);
        check("b2b_opB", unit_operandB, 32'd9);
        wait_wb(lat, slo);
        check("b2b_lat2", lat, 18);
        @(negedge clock);

        // Timeout with a stale ready during START.
        never_rdy = 1'b1;
        n_mult = 0;
        sb.push_back('{32'd0, 1'b1, 5'd12});
        drive_req(OP_M, 32'd5, 32'd5, 5'd12);
        @(negedge clock);
        req_valid = 1'b0;
        stale_rdy = 1'b1;
        @(negedge clock);
        stale_rdy = 1'b0;
        wait_wb(lat, slo);
        check("timeout_lat", lat, 40);
        check("timeout_pulses", n_mult, 1);
        @(negedge clock);
        never_rdy = 1'b0;

        // Reset in the middle of WAIT aborts without writeback.
        seen0 = wb_seen;
        drive_req(OP_M, 32'd2, 32'd3, 5'd13);
        @(negedge clock);
        req_valid = 1'b0;
        repeat (4) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        check("mid_rst_busy", 32'(busy), 0);
        check("mid_rst_stall", 32'(stall), 0);
        check("mid_rst_wb_valid", 32'(wb_valid), 0);
        check("mid_rst_ctrl", {30'd0, unit_ctrl_MULT, unit_ctrl_DIV}, 0);
        check("mid_rst_opA", unit_operandA, 0);
        reset = 1'b0;
        repeat (25) @(negedge clock);
        check("mid_rst_no_wb", wb_seen, seen0);
        run_one(vecs[0]);

        check("sb_drained", sb.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
